// File: rtl/pc_ras_if.sv
// Fetch-side bundle between next-PC select logic and pc_ras_unit.
// With PC_ALIGN_CHECK_EN defined, the bundle also carries the misalign pulse.
`timescale 1ns/1ps
interface pc_ras_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             call_valid;
  logic [WIDTH-1:0] call_target;
  logic             ret_valid;
  logic [WIDTH-1:0] ret_target;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_seq;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_miss;
  logic             ras_overflow;
`ifdef PC_ALIGN_CHECK_EN
  logic             misalign;
`endif

  modport master (
    output en, redirect_valid, redirect_pc, call_valid, call_target,
           ret_valid, ret_target,
`ifdef PC_ALIGN_CHECK_EN
    input  misalign,
`endif
    input  pc, pc_seq, ras_empty, ras_full, ras_miss, ras_overflow
  );

  modport slave (
    input  en, redirect_valid, redirect_pc, call_valid, call_target,
           ret_valid, ret_target,
`ifdef PC_ALIGN_CHECK_EN
    output misalign,
`endif
    output pc, pc_seq, ras_empty, ras_full, ras_miss, ras_overflow
  );
endinterface

// File: rtl/pc_ras_unit.sv
// Fetch PC register with prioritised redirects and a circular return-address stack.
// Optional target alignment check/forcing is enabled by defining PC_ALIGN_CHECK_EN.
`timescale 1ns/1ps
module pc_ras_unit #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VEC   = '0,
  parameter int               INSTR_BYTES = 4,
  parameter int               RAS_DEPTH   = 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_ras_if.slave  bus
);
  localparam int               PTR_W    = $clog2(RAS_DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [WIDTH-1:0] STEP     = WIDTH'(INSTR_BYTES);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);
`ifdef PC_ALIGN_CHECK_EN
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INSTR_BYTES - 1);
`endif

  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             miss_reg, miss_next;
  logic             ovf_reg, ovf_next;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] ras_top;
  logic [WIDTH-1:0] target;
  logic             load;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic             ras_empty;

  assign pc_seq    = pc_reg + STEP;
  assign ras_top   = ras_mem[ptr_reg];
  assign ras_empty = (count_reg == '0);

  always_comb begin
    target     = pc_seq;
    load       = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = ptr_reg;
    ptr_next   = ptr_reg;
    count_next = count_reg;
    miss_next  = 1'b0;
    ovf_next   = ovf_reg;
    if (bus.en) begin
      if (bus.redirect_valid) begin
        target = bus.redirect_pc;
        load   = 1'b1;
      end else if (bus.ret_valid && bus.call_valid) begin
        load = 1'b1;
        if (!ras_empty) begin
          // Indirect call through a return: swap the top entry in place.
          target = ras_top;
          wr_en  = 1'b1;
        end else begin
          target     = bus.ret_target;
          ptr_next   = ptr_reg + PTR_W'(1);
          wr_idx     = ptr_reg + PTR_W'(1);
          wr_en      = 1'b1;
          count_next = CNT_W'(1);
          miss_next  = 1'b1;
        end
      end else if (bus.ret_valid) begin
        load = 1'b1;
        if (!ras_empty) begin
          target     = ras_top;
          ptr_next   = ptr_reg - PTR_W'(1);
          count_next = count_reg - CNT_W'(1);
        end else begin
          target    = bus.ret_target;
          miss_next = 1'b1;
        end
      end else if (bus.call_valid) begin
        // Pointer wraps naturally; when full the oldest slot is the one reused.
        target   = bus.call_target;
        load     = 1'b1;
        ptr_next = ptr_reg + PTR_W'(1);
        wr_idx   = ptr_reg + PTR_W'(1);
        wr_en    = 1'b1;
        if (count_reg == FULL_CNT) ovf_next = 1'b1;
        else                       count_next = count_reg + CNT_W'(1);
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_reg, misalign_next;
  always_comb begin
    misalign_next = load && ((target & ALIGN_MASK) != '0);
    if (!bus.en)   pc_next = pc_reg;
    else if (load) pc_next = target & ~ALIGN_MASK;
    else           pc_next = pc_seq;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_reg <= 1'b0;
    else     misalign_reg <= misalign_next;
  end
  assign bus.misalign = misalign_reg;
`else
  always_comb begin
    if (!bus.en)   pc_next = pc_reg;
    else if (load) pc_next = target;
    else           pc_next = pc_seq;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg    <= RESET_VEC;
      ptr_reg   <= '0;
      count_reg <= '0;
      miss_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      ptr_reg   <= ptr_next;
      count_reg <= count_next;
      miss_reg  <= miss_next;
      ovf_reg   <= ovf_next;
    end
  end

  // Stack contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) ras_mem[wr_idx] <= pc_seq;
  end

  assign bus.pc           = pc_reg;
  assign bus.pc_seq       = pc_seq;
  assign bus.ras_empty    = ras_empty;
  assign bus.ras_full     = (count_reg == FULL_CNT);
  assign bus.ras_miss     = miss_reg;
  assign bus.ras_overflow = ovf_reg;
endmodule
